// File: rtl/decode_queue_stage.sv
// Decode/queue stage: buffers fetched RV32I instructions in a small FIFO and
// presents one registered decode bundle per cycle to execute.
module decode_queue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int IQ_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [DATA_WIDTH-1:0]   in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_pc,
  output logic [4:0]              out_rs1,
  output logic [4:0]              out_rs2,
  output logic [4:0]              out_rd,
  output logic [DATA_WIDTH-1:0]   out_imm,
  output logic [2:0]              out_alu_ctrl,
  output logic                    out_alu_src,
  output logic                    out_reg_write,
  output logic                    out_mem_write,
  output logic [1:0]              out_result_src,
  output logic                    out_branch,
  output logic                    out_bne,
  output logic                    out_jump,
  output logic                    out_illegal,
  output logic [$clog2(IQ_DEPTH):0] iq_count
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(IQ_DEPTH);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  logic [31:0]           instr_mem [IQ_DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem    [IQ_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;

  // in_ready looks only at the registered count, so a full queue never takes
  // a push even when the head is being popped in the same cycle.
  assign in_ready = (iq_count != FULL_COUNT);
  assign push     = in_valid && in_ready;
  assign pop      = (!out_valid || out_ready) && (iq_count != '0);

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      iq_count <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      iq_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   iq_count <= iq_count + 1'b1;
        2'b01:   iq_count <= iq_count - 1'b1;
        default: ;
      endcase
    end
  end

  logic [31:0]           head_instr;
  logic [DATA_WIDTH-1:0] head_pc;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  funct7_5;
  logic [31:0]           imm_i, imm_s, imm_b, imm_j, imm_u;

  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];
  assign opcode     = head_instr[6:0];
  assign funct3     = head_instr[14:12];
  assign funct7_5   = head_instr[30];

  assign imm_i = {{20{head_instr[31]}}, head_instr[31:20]};
  assign imm_s = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
  assign imm_b = {{20{head_instr[31]}}, head_instr[7], head_instr[30:25],
                  head_instr[11:8], 1'b0};
  assign imm_j = {{12{head_instr[31]}}, head_instr[19:12], head_instr[20],
                  head_instr[30:21], 1'b0};
  assign imm_u = {head_instr[31:12], 12'b0};

  logic [31:0] dec_imm32;
  logic [4:0]  dec_rs1;
  logic [2:0]  dec_alu_ctrl;
  logic        dec_alu_src, dec_reg_write, dec_mem_write;
  logic [1:0]  dec_result_src;
  logic        dec_branch, dec_bne, dec_jump, dec_illegal;

  // Illegal encodings fall through to a common clear so no control leaks out.
  always_comb begin
    dec_imm32      = '0;
    dec_rs1        = head_instr[19:15];
    dec_alu_ctrl   = ALU_ADD;
    dec_alu_src    = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_write  = 1'b0;
    dec_result_src = 2'b00;
    dec_branch     = 1'b0;
    dec_bne        = 1'b0;
    dec_jump       = 1'b0;
    dec_illegal    = 1'b0;
    case (opcode)
      OP_R: begin
        dec_reg_write = 1'b1;
        case ({funct7_5, funct3})
          4'b0000: dec_alu_ctrl = ALU_ADD;
          4'b1000: dec_alu_ctrl = ALU_SUB;
          4'b0111: dec_alu_ctrl = ALU_AND;
          4'b0110: dec_alu_ctrl = ALU_OR;
          4'b0010: dec_alu_ctrl = ALU_SLT;
          4'b0100: dec_alu_ctrl = ALU_XOR;
          4'b0001: dec_alu_ctrl = ALU_SLL;
          4'b0101: dec_alu_ctrl = ALU_SRL;
          default: dec_illegal  = 1'b1;
        endcase
      end
      OP_IALU: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm32     = imm_i;
        case (funct3)
          3'b000:  dec_alu_ctrl = ALU_ADD;
          3'b111:  dec_alu_ctrl = ALU_AND;
          3'b110:  dec_alu_ctrl = ALU_OR;
          3'b010:  dec_alu_ctrl = ALU_SLT;
          3'b100:  dec_alu_ctrl = ALU_XOR;
          3'b001:  dec_alu_ctrl = ALU_SLL;
          3'b101:  dec_alu_ctrl = ALU_SRL;
          default: dec_illegal  = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec_reg_write  = 1'b1;
        dec_alu_src    = 1'b1;
        dec_result_src = 2'b01;
        dec_imm32      = imm_i;
        dec_illegal    = (funct3 != 3'b010);
      end
      OP_STORE: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm32     = imm_s;
        dec_illegal   = (funct3 != 3'b010);
      end
      OP_BRANCH: begin
        dec_branch   = 1'b1;
        dec_bne      = (funct3 == 3'b001);
        dec_alu_ctrl = ALU_SUB;
        dec_imm32    = imm_b;
        dec_illegal  = (funct3 != 3'b000) && (funct3 != 3'b001);
      end
      OP_JAL: begin
        dec_jump       = 1'b1;
        dec_reg_write  = 1'b1;
        dec_result_src = 2'b10;
        dec_imm32      = imm_j;
      end
      OP_LUI: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm32     = imm_u;
        dec_rs1       = 5'd0;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_imm32      = '0;
      dec_alu_ctrl   = ALU_ADD;
      dec_alu_src    = 1'b0;
      dec_reg_write  = 1'b0;
      dec_mem_write  = 1'b0;
      dec_result_src = 2'b00;
      dec_branch     = 1'b0;
      dec_bne        = 1'b0;
      dec_jump       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_rs1        <= '0;
      out_rs2        <= '0;
      out_rd         <= '0;
      out_imm        <= '0;
      out_alu_ctrl   <= '0;
      out_alu_src    <= 1'b0;
      out_reg_write  <= 1'b0;
      out_mem_write  <= 1'b0;
      out_result_src <= '0;
      out_branch     <= 1'b0;
      out_bne        <= 1'b0;
      out_jump       <= 1'b0;
      out_illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid      <= 1'b1;
      out_pc         <= head_pc;
      out_rs1        <= dec_rs1;
      out_rs2        <= head_instr[24:20];
      out_rd         <= head_instr[11:7];
      out_imm        <= DATA_WIDTH'($signed(dec_imm32));
      out_alu_ctrl   <= dec_alu_ctrl;
      out_alu_src    <= dec_alu_src;
      out_reg_write  <= dec_reg_write;
      out_mem_write  <= dec_mem_write;
      out_result_src <= dec_result_src;
      out_branch     <= dec_branch;
      out_bne        <= dec_bne;
      out_jump       <= dec_jump;
      out_illegal    <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
